rst_seq: RTL and testbench



---
 rtl/rst_seq.sv | 137 +++++++++++++
 tb/tb_rst_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Brief    : Reset sequencer for the clkgen output domain. It qualifies MMCM
//            lock, then releases the periph reset and later the core reset.
//            Optional loss counter: define RST_SEQ_LOSS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq #(
    parameter int LOCK_CYCLES   = 64,
    parameter int CORE_DELAY    = 16,
    parameter int SW_RST_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_rst_req,
    output logic       periph_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic [2:0] state_o
`ifdef RST_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int C_MAX_A = (LOCK_CYCLES > CORE_DELAY) ? LOCK_CYCLES : CORE_DELAY;
    localparam int C_MAX   = (C_MAX_A > SW_RST_CYCLES) ? C_MAX_A : SW_RST_CYCLES;
    localparam int CNT_W   = $clog2(C_MAX + 1);

    localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_core_last = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] c_sw_last   = CNT_W'(SW_RST_CYCLES - 1);

    localparam logic [2:0] c_wait_lock  = 3'd0;
    localparam logic [2:0] c_stable     = 3'd1;
    localparam logic [2:0] c_rel_periph = 3'd2;
    localparam logic [2:0] c_run        = 3'd3;
    localparam logic [2:0] c_sw_rst     = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_periph_rst_n;
    logic                   r_core_rst_n;
    logic                   r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Counter only advances while dwelling in a timed state; any state change clears it.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            c_wait_lock: begin
                if (w_lock_s) w_next = c_stable;
            end
            c_stable: begin
                if (!w_lock_s)                w_next = c_wait_lock;
                else if (r_cnt == c_lock_last) w_next = c_rel_periph;
                else                          w_cnt_next = r_cnt + 1'b1;
            end
            c_rel_periph: begin
                if (!w_lock_s)                w_next = c_wait_lock;
                else if (r_cnt == c_core_last) w_next = c_run;
                else                          w_cnt_next = r_cnt + 1'b1;
            end
            c_run: begin
                if (!w_lock_s)       w_next = c_wait_lock;
                else if (sw_rst_req) w_next = c_sw_rst;
            end
            c_sw_rst: begin
                if (!w_lock_s)              w_next = c_wait_lock;
                else if (r_cnt == c_sw_last) w_next = c_run;
                else                        w_cnt_next = r_cnt + 1'b1;
            end
            default: w_next = c_wait_lock;
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_wait_lock;
            r_cnt          <= '0;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_periph_rst_n <= (w_next == c_rel_periph) || (w_next == c_run) ||
                              (w_next == c_sw_rst);
            r_core_rst_n   <= (w_next == c_run);
            r_ready        <= (w_next == c_run);
        end
    end

    assign periph_rst_n = r_periph_rst_n;
    assign core_rst_n   = r_core_rst_n;
    assign ready        = r_ready;
    assign state_o      = r_state;

`ifdef RST_SEQ_LOSS_CNT_EN
    logic       w_loss_evt;
    logic [7:0] r_loss_cnt;

    assign w_loss_evt = !w_lock_s && (r_state >= c_stable) && (r_state <= c_sw_rst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Self-checking bench for rst_seq against a lock-window model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

    localparam int LOCK_CYCLES   = 64;
    localparam int CORE_DELAY    = 16;
    localparam int SW_RST_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       sw_rst_req;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic [2:0] state_o;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    always #5 clk = ~clk;

    rst_seq #(
        .LOCK_CYCLES   (LOCK_CYCLES),
        .CORE_DELAY    (CORE_DELAY),
        .SW_RST_CYCLES (SW_RST_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .sw_rst_req   (sw_rst_req),
        .periph_rst_n (periph_rst_n),
        .core_rst_n   (core_rst_n),
        .ready        (ready),
        .state_o      (state_o)
`ifdef RST_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt     (loss_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: m_n is the run length of consecutive edges that saw a locked sync
    // output; the phase follows from that length alone, plus a sw pulse timer.
    bit q[$];
    int m_n, m_sw_left, m_state, m_loss;

    task automatic m_reset();
        q = {};
        for (int i = 0; i < SYNC_STAGES; i++) q.push_back(1'b0);
        m_n = 0; m_sw_left = 0; m_state = 0; m_loss = 0;
    endtask

    task automatic m_edge();
        bit ls;
        int prev;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ls = q[0];
        q.push_back(locked);
        void'(q.pop_front());
        prev = m_state;
        if (!ls) begin
            if (prev != 0 && m_loss < 255) m_loss++;
            m_n = 0; m_sw_left = 0; m_state = 0;
        end else begin
            if (m_n < 1000000) m_n++;
            if (m_n <= LOCK_CYCLES)                   m_state = 1;
            else if (m_n <= LOCK_CYCLES + CORE_DELAY) m_state = 2;
            else if (m_sw_left > 0) begin
                m_sw_left--;
                m_state = (m_sw_left > 0) ? 4 : 3;
            end else if (prev == 3 && sw_rst_req) begin
                m_sw_left = SW_RST_CYCLES;
                m_state   = 4;
            end else m_state = 3;
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("state",  state_o,      m_state);
        chk("periph", periph_rst_n, (m_state == 2 || m_state == 3 || m_state == 4));
        chk("core",   core_rst_n,   (m_state == 3));
        chk("ready",  ready,        (m_state == 3));
`ifdef RST_SEQ_LOSS_CNT_EN
        chk("loss_cnt", loss_cnt, m_loss);
`endif
    endtask

    // Hold locked high and report the edge (counted from now) of each release.
    task automatic measure_rise(input int max_edges, output int p_edge, output int c_edge);
        p_edge = 0; c_edge = 0;
        for (int e = 1; e <= max_edges; e++) begin
            step();
            if (periph_rst_n === 1'b1 && p_edge == 0) p_edge = e;
            if (core_rst_n === 1'b1 && c_edge == 0) c_edge = e;
        end
    endtask

    int p_e, c_e, lowc, guard;
    int seq[$];

    initial begin
        rst_n = 1'b0; locked = 1'b0; sw_rst_req = 1'b0;
        m_reset();
        repeat (5) step();
        chk("reset_periph", periph_rst_n, 0);
        chk("reset_state",  state_o, 0);
        rst_n = 1'b1;
        step();

        // Clean start-up with state sequence capture
        locked = 1'b1;
        seq = {0};
        p_e = 0; c_e = 0;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (int'(state_o) != seq[$]) seq.push_back(int'(state_o));
            if (periph_rst_n === 1'b1 && p_e == 0) p_e = e;
            if (core_rst_n === 1'b1 && c_e == 0) c_e = e;
        end
        chk("periph_rise_edge", p_e, SYNC_STAGES + 1 + LOCK_CYCLES);
        chk("core_rise_edge",   c_e, SYNC_STAGES + 1 + LOCK_CYCLES + CORE_DELAY);
        chk("seq_len", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++) chk("seq_state", seq[i], i);

        // Software core-reset pulse with an ignored retrigger
        lowc = 0;
        sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
        if (core_rst_n === 1'b0) lowc++;
        for (int k = 0; k < 12; k++) begin
            sw_rst_req = (k == 3);
            step();
            if (core_rst_n === 1'b0) lowc++;
        end
        sw_rst_req = 1'b0;
        chk("sw_low_cycles", lowc, SW_RST_CYCLES);

        // Lock loss while in SW_RST
        sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
        step();
        locked = 1'b0;
        step();
        step(); chk("loss_e2_periph", periph_rst_n, 1);
        step(); chk("loss_e3_periph", periph_rst_n, 0);
        chk("loss_e3_state", state_o, 0);
        locked = 1'b1;
        repeat (90) step();
        chk("relock_state", state_o, 3);

        // Short lock glitch restarts qualification
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (30) step();
        locked = 1'b0;
        repeat (10) step();
        chk("glitch_periph", periph_rst_n, 0);
        locked = 1'b1;
        measure_rise(100, p_e, c_e);
        chk("glitch_periph_edge", p_e, SYNC_STAGES + 1 + LOCK_CYCLES);
        chk("glitch_core_edge",   c_e, SYNC_STAGES + 1 + LOCK_CYCLES + CORE_DELAY);
`ifdef RST_SEQ_LOSS_CNT_EN
        chk("glitch_loss_cnt", loss_cnt, 1);
`endif

        // Asynchronous reset mid-REL_PERIPH
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (SYNC_STAGES + 1 + LOCK_CYCLES + 5) step();
        chk("mid_rel_state", state_o, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("async_periph", periph_rst_n, 0);
        chk("async_state",  state_o, 0);
        m_reset();
        step();
        rst_n = 1'b1;
        measure_rise(70, p_e, c_e);
        chk("async_requal_edge", p_e, SYNC_STAGES + 1 + LOCK_CYCLES);

        // Randomized lock patterns and software requests
        for (int s = 0; s < 40; s++) begin
            int len;
            locked = ($urandom_range(0, 2) != 0);
            len = locked ? $urandom_range(1, 150) : $urandom_range(1, 15);
            for (int c = 0; c < len; c++) begin
                sw_rst_req = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        sw_rst_req = 1'b0;

`ifdef RST_SEQ_LOSS_CNT_EN
        // Loss counter saturation from repeated RUN lock losses
        rst_n = 1'b0; locked = 1'b0; step(); rst_n = 1'b1;
        for (int ev = 0; ev < 300; ev++) begin
            locked = 1'b1;
            guard = 0;
            while (m_state != 3 && guard < 200) begin
                step();
                guard++;
            end
            if (m_state != 3) chk("sat_reach_run_timeout", state_o, 3);
            locked = 1'b0;
            repeat (3) step();
        end
        chk("loss_cnt_saturated", loss_cnt, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
